// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB receive packet controller.
// Holds the FSM state encoding, error causes and PID field helpers.
package usb_rx_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned PID_W   = 4;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h54;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_SYNC_WAIT = 4'd1,
        ST_SYNC_CHK  = 4'd2,
        ST_PID_WAIT  = 4'd3,
        ST_PID_CHK   = 4'd4,
        ST_DATA_WAIT = 4'd5,
        ST_DATA_WR   = 4'd6,
        ST_CRC_CHK   = 4'd7,
        ST_EOP_WAIT  = 4'd8,
        ST_ERROR     = 4'd9
    } state_t;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE    = 3'd0,
        ERR_SYNC    = 3'd1,
        ERR_PID     = 3'd2,
        ERR_LEN     = 3'd3,
        ERR_EOP     = 3'd4,
        ERR_CRC     = 3'd5,
        ERR_TIMEOUT = 3'd6,
        ERR_OVERRUN = 3'd7
    } err_t;

    // State-decoded status outputs, registered together
    typedef struct packed {
        logic receiving;
        logic crc_enable;
        logic crc_clear;
        logic rcv_error;
    } moore_out_t;

    // Upper nibble of a PID byte must be the complement of the lower nibble
    function automatic logic pid_check(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    function automatic logic [PID_W-1:0] pid_field(input logic [7:0] b);
        return b[PID_W-1:0];
    endfunction

endpackage

// File: rtl/usb_rx_timeout.sv
// Saturating idle-cycle counter; expired stays high once LIMIT cycles
// have passed without a clear.
module usb_rx_timeout #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(LIMIT));

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// USB receive packet controller: checks SYNC/PID, counts and forwards bytes
// to the RX FIFO, and reports the first error cause of each packet.
module usb_rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned MAX_BYTES   = 64,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned TIMEOUT_CLK = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rx_data,
    input  logic             eop,
    input  logic             crc_ok,
    input  logic             fifo_full,
    output logic             receiving,
    output logic             write_enable,
    output logic             crc_enable,
    output logic             crc_clear,
    output logic [3:0]       pid_out,
    output logic             pid_valid,
    output logic [CNT_W-1:0] byte_count,
    output logic             pkt_done,
    output logic             rcv_error,
    output logic [2:0]       err_code
);

    state_t     state;
    state_t     next_state;
    err_t       err_q;
    err_t       err_cause;
    moore_out_t mo_q;
    moore_out_t mo_nxt;

    logic        write_req;
    logic        done_req;
    logic        pid_accept;
    logic        data_write;
    logic        pkt_start;
    logic        err_set;
    logic [31:0] cnt_inc;
    logic        to_active;
    logic        to_clear;
    logic        to_expired;

    // Idle-line watchdog runs only while a packet is actively being decoded
    assign to_active = (state != ST_IDLE) && (state != ST_ERROR) && (state != ST_EOP_WAIT);
    assign to_clear  = shift_enable || !to_active;

    usb_rx_timeout #(
        .LIMIT (TIMEOUT_CLK)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_active),
        .expired (to_expired)
    );

    // State register plus registered strobes and state-decoded outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            write_enable <= 1'b0;
            pkt_done     <= 1'b0;
            mo_q         <= '{receiving: 1'b0, crc_enable: 1'b0, crc_clear: 1'b1, rcv_error: 1'b0};
        end else begin
            state        <= next_state;
            write_enable <= write_req;
            pkt_done     <= done_req;
            mo_q         <= mo_nxt;
        end
    end

    // Per-packet bookkeeping: PID latch, written-byte count, first error cause
    always_ff @(posedge clk) begin
        if (rst) begin
            pid_out    <= '0;
            pid_valid  <= 1'b0;
            byte_count <= '0;
            err_q      <= ERR_NONE;
        end else begin
            if (pkt_start) begin
                pid_valid  <= 1'b0;
                byte_count <= '0;
                err_q      <= ERR_NONE;
            end
            if (pid_accept) begin
                pid_out   <= pid_field(rx_data);
                pid_valid <= 1'b1;
            end
            if (data_write) begin
                byte_count <= byte_count + CNT_W'(1);
            end
            if (err_set) begin
                err_q <= err_cause;
            end
        end
    end

    // Next-state logic; the watchdog overrides any other transition
    always_comb begin
        next_state = state;
        err_cause  = ERR_NONE;
        write_req  = 1'b0;
        done_req   = 1'b0;
        pid_accept = 1'b0;
        data_write = 1'b0;
        pkt_start  = 1'b0;
        cnt_inc    = 32'(byte_count) + 32'd1;

        if (to_active && to_expired) begin
            next_state = ST_ERROR;
            err_cause  = ERR_TIMEOUT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_edge) begin
                        next_state = ST_SYNC_WAIT;
                        pkt_start  = 1'b1;
                    end
                end
                ST_SYNC_WAIT: begin
                    if (byte_received) begin
                        next_state = ST_SYNC_CHK;
                    end else if (eop) begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_EOP;
                    end
                end
                ST_SYNC_CHK: begin
                    if (rx_data == SYNC_BYTE) begin
                        next_state = ST_PID_WAIT;
                    end else begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_SYNC;
                    end
                end
                ST_PID_WAIT: begin
                    if (eop) begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_EOP;
                    end else if (byte_received) begin
                        next_state = ST_PID_CHK;
                    end
                end
                ST_PID_CHK: begin
                    if (!pid_check(rx_data)) begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_PID;
                    end else if (fifo_full) begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_OVERRUN;
                    end else begin
                        next_state = ST_DATA_WAIT;
                        pid_accept = 1'b1;
                        write_req  = 1'b1;
                    end
                end
                ST_DATA_WAIT: begin
                    if (eop) begin
                        if (!byte_received && (byte_count >= CNT_W'(2))) begin
                            next_state = ST_CRC_CHK;
                        end else begin
                            next_state = ST_ERROR;
                            err_cause  = ERR_EOP;
                        end
                    end else if (byte_received) begin
                        next_state = ST_DATA_WR;
                    end
                end
                ST_DATA_WR: begin
                    if (cnt_inc > MAX_BYTES) begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_LEN;
                    end else if (fifo_full) begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_OVERRUN;
                    end else begin
                        next_state = ST_DATA_WAIT;
                        write_req  = 1'b1;
                        data_write = 1'b1;
                    end
                end
                ST_CRC_CHK: begin
                    if (crc_ok) begin
                        next_state = ST_EOP_WAIT;
                        done_req   = 1'b1;
                    end else begin
                        next_state = ST_ERROR;
                        err_cause  = ERR_CRC;
                    end
                end
                ST_EOP_WAIT: begin
                    if (!eop && d_edge) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (!eop) begin
                        next_state = ST_IDLE;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    assign err_set = (next_state == ST_ERROR) && (state != ST_ERROR);

    // Status outputs decoded from the state being entered
    always_comb begin
        mo_nxt = '0;
        case (next_state)
            ST_IDLE: begin
                mo_nxt.crc_clear = 1'b1;
            end
            ST_DATA_WAIT: begin
                mo_nxt.receiving  = 1'b1;
                mo_nxt.crc_enable = 1'b1;
            end
            ST_ERROR: begin
                mo_nxt.receiving = 1'b1;
                mo_nxt.rcv_error = 1'b1;
            end
            default: begin
                mo_nxt.receiving = 1'b1;
            end
        endcase
    end

    assign receiving  = mo_q.receiving;
    assign crc_enable = mo_q.crc_enable;
    assign crc_clear  = mo_q.crc_clear;
    assign rcv_error  = mo_q.rcv_error;
    assign err_code   = err_q;

endmodule
